// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter slice.
//   state_e     - sequencer states of the frame FSM
//   phase_e     - which part of the packet (SOF, ID, payload, checksum) is next
//   SOF_DEFAULT - default start-of-frame marker byte
//   BYTE_W      - UART byte width
//   chk_update  - running XOR checksum step
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PH_SOF     = 2'd0,
        PH_ID      = 2'd1,
        PH_PAYLOAD = 2'd2,
        PH_CHK     = 2'd3
    } phase_e;

    function automatic logic [BYTE_W-1:0] chk_update(input logic [BYTE_W-1:0] chk,
                                                      input logic [BYTE_W-1:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i    - request vector, one bit per port
//   ptr_i    - highest-priority port for this pick; search wraps from here
//   onehot_o - one-hot winner (all zero when no request)
//   idx_o    - winner index (zero when no request)
//   any_o    - at least one request present
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] onehot_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    int   cand_s;
    logic found_s;

    // Walk ports starting at ptr_i; the first requester found wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_s  = 1'b0;
        cand_s   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = (int'(ptr_i) + i) % NUM_PORTS;
            if (!found_s && req_i[IDX_W'(cand_s)]) begin
                found_s                   = 1'b1;
                idx_o                     = IDX_W'(cand_s);
                onehot_o[IDX_W'(cand_s)]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter and frame sequencer in
// front of a single uart_tx byte transmitter.
//   req_data_i   - payload byte per port, port p on [8p+7:8p]
//   req_valid_i  - byte available per port
//   req_last_i   - byte is the last of its packet
//   req_ready_o  - byte consumed this cycle (only the granted port, only in payload load)
//   tx_data_o    - byte handed to uart_tx (registered)
//   tx_start_o   - one-cycle start pulse to uart_tx (registered)
//   tx_busy_i    - uart_tx busy flag
//   grant_id_o   - currently granted port
//   pkt_active_o - high from grant until the packet's final frame completes
// With HDR_EN=1 each packet goes out as SOF, port ID, payload, XOR checksum
// (checksum covers the ID byte and the payload).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int              NUM_PORTS = 4,
    parameter logic [7:0]      SOF_BYTE  = SOF_DEFAULT,
    parameter bit              HDR_EN    = 1'b1,
    localparam int             ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BYTE_W*NUM_PORTS-1:0]   req_data_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS-1:0]          req_last_i,
    output logic [NUM_PORTS-1:0]          req_ready_o,
    output logic [BYTE_W-1:0]             tx_data_o,
    output logic                          tx_start_o,
    input  logic                          tx_busy_i,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          pkt_active_o
);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0]  chk_q, chk_d;
    logic               last_q, last_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               pkt_active_q, pkt_active_d;

    logic [NUM_PORTS-1:0] win_onehot_s;
    logic [ID_W-1:0]      win_idx_s;
    logic                 win_any_s;
    logic [BYTE_W-1:0]    cur_byte_s;
    logic                 cur_valid_s;
    logic                 cur_last_s;
    logic [ID_W-1:0]      rr_next_s;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (win_onehot_s),
        .idx_o    (win_idx_s),
        .any_o    (win_any_s)
    );

    assign cur_byte_s  = req_data_i[int'(grant_q)*BYTE_W +: BYTE_W];
    assign cur_valid_s = req_valid_i[grant_q];
    assign cur_last_s  = req_last_i[grant_q];
    assign rr_next_s   = ID_W'((int'(grant_q) + 1) % NUM_PORTS);

    // Next-state, datapath and req_ready decode for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        chk_d        = chk_q;
        last_d       = last_q;
        tx_data_d    = tx_data_q;
        pkt_active_d = pkt_active_q;
        req_ready_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_any_s) begin
                    grant_d      = win_idx_s;
                    phase_d      = HDR_EN ? PH_SOF : PH_PAYLOAD;
                    chk_d        = 8'h00;
                    pkt_active_d = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                case (phase_q)
                    PH_SOF: begin
                        tx_data_d = SOF_BYTE;
                        state_d   = ST_START;
                    end
                    PH_ID: begin
                        tx_data_d = BYTE_W'(grant_q);
                        chk_d     = BYTE_W'(grant_q);
                        state_d   = ST_START;
                    end
                    PH_CHK: begin
                        tx_data_d = chk_q;
                        state_d   = ST_START;
                    end
                    PH_PAYLOAD: begin
                        // Ready is offered only here and only to the granted port.
                        req_ready_o[grant_q] = 1'b1;
                        if (cur_valid_s) begin
                            tx_data_d = cur_byte_s;
                            chk_d     = chk_update(chk_q, cur_byte_s);
                            last_d    = cur_last_s;
                            state_d   = ST_START;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_LOAD;
                    case (phase_q)
                        PH_SOF:  phase_d = PH_ID;
                        PH_ID:   phase_d = PH_PAYLOAD;
                        PH_PAYLOAD: begin
                            if (last_q && HDR_EN) begin
                                phase_d = PH_CHK;
                            end else if (last_q) begin
                                state_d      = ST_IDLE;
                                rr_ptr_d     = rr_next_s;
                                pkt_active_d = 1'b0;
                            end else begin
                                phase_d = PH_PAYLOAD;
                            end
                        end
                        PH_CHK: begin
                            state_d      = ST_IDLE;
                            rr_ptr_d     = rr_next_s;
                            pkt_active_d = 1'b0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered pulse lines up with the single START cycle.
        tx_start_d = (state_d == ST_START);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_SOF;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            chk_q        <= 8'h00;
            last_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            pkt_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            chk_q        <= chk_d;
            last_q       <= last_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            pkt_active_q <= pkt_active_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign grant_id_o   = grant_q;
    assign pkt_active_o = pkt_active_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter and frame sequencer that shares a single `uart_tx` byte transmitter among `NUM_PORTS` byte-stream requesters. It wraps each granted packet as SOF byte, port-ID byte, payload and XOR checksum. It drives `tx_data`/`tx_start` and follows `tx_busy` so that exactly one byte is handed over per UART frame. It sits between on-chip debug/telemetry producers and the `uart_tx` instance on the board UART pin.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `SOF_BYTE`, 8'hA5: start-of-frame marker byte.
- `HDR_EN`, 1: 1 = send SOF, ID and checksum; 0 = raw payload only.
- `clk`  in  1  system clock, same domain as `uart_tx`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_data`  in  `8*NUM_PORTS`  payload byte per port; port p uses bits [8p+7:8p].
- `req_valid`  in  `NUM_PORTS`  byte available on port p.
- `req_last`  in  `NUM_PORTS`  byte on port p is the final byte of its packet.
- `req_ready`  out  `NUM_PORTS`  byte on port p is consumed this cycle (valid&ready).
- `tx_data`  out  8  byte to `uart_tx`, registered.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`, registered.
- `tx_busy`  in  1  busy flag from `uart_tx`.
- `grant_id`  out  `$clog2(NUM_PORTS)`  currently granted port.
- `pkt_active`  out  1  high from grant until the last byte of the packet completes.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE. Phase register: SOF, ID, PAYLOAD, CHK.
- IDLE:
  - If any `req_valid` is high, latch `grant_id` as the round-robin winner. The search starts at `rr_ptr` and wraps.
  - Set phase to SOF (HDR_EN=1) or PAYLOAD (HDR_EN=0), clear checksum, set `pkt_active`, then go to LOAD.
- LOAD:
  - SOF loads `SOF_BYTE`; ID loads the zero-extended `grant_id` and initialises the checksum to it; CHK loads the checksum. Each then goes to START.
  - PAYLOAD: drive `req_ready[grant_id]`=1 combinationally. On `req_valid`, load the byte, XOR it into the checksum, latch `req_last`, then go to START. Otherwise stay in LOAD.
- START: `tx_start`=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy`=0, then advance the phase:
  - SOF→ID.
  - ID→PAYLOAD.
  - PAYLOAD→CHK if the latched last is set (HDR_EN=0: go to IDLE); otherwise stay in PAYLOAD.
  - CHK→IDLE.
  - Every path other than one to IDLE continues to LOAD.
- On return to IDLE: `rr_ptr` ← `grant_id`+1 mod `NUM_PORTS`, and `pkt_active` clears.
- No preemption. A granted port that drops `req_valid` mid-packet stalls the arbiter in LOAD indefinitely. Other ports wait.
- Checksum is an 8-bit XOR over the ID byte and all payload bytes.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `pkt_active`=0.
  - `rr_ptr`=0, checksum=0, state IDLE.
- `req_ready` is 0 outside LOAD/PAYLOAD and is never high for more than one port.
- Latency:
  - `req_valid` seen in IDLE at cycle n gives `tx_start` at n+2.
  - A `tx_busy` fall seen at cycle t gives the next `tx_start` at t+2.
- `tx_data` is stable from the LOAD exit until the next LOAD. `tx_start` is asserted only while `tx_busy`=0.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr` wins.
- `req_valid` is ignored for ports not granted. Payload is consumed one byte per UART frame.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values. The partial frame is dropped, and `uart_tx` shares `rst_n`.
- `tx_busy` stuck low after START hangs in WAIT_BUSY by design; a watchdog is out of scope.

## Structure
- Shared package `uart_pkg`:
  - state enum and phase enum;
  - `SOF_DEFAULT` = 8'hA5;
  - byte width constant.
- One sub-module `rr_arbiter`: combinational round-robin pick from `req_valid` and `rr_ptr`, producing a one-hot and an index.
- FSM, checksum and `tx_*` registers live in `uart_tx_arbiter`. The bench instantiates `uart_tx_arbiter` together with `uart_tx` at CLK_FREQ/BAUD_RATE=16 for fast simulation.

## Test plan
- Port 0 sends a single byte 0x3C with last=1 → the line decodes A5, 00, 3C, 3C; `req_ready[0]` pulses once; `pkt_active` falls after the 4th frame.
- Port 2 sends a 3-byte packet 0x11, 0x22, 0x44 → the line decodes A5, 02, 11, 22, 44, 75; `grant_id`=2 throughout.
- All ports valid at once from reset → packets are sent in order 0, 1, 2, 3. A second round after port 0 refills starts at port 0 only after port 3 is done.
- Port 1 drops valid for 50 cycles mid-packet while port 3 is valid → no port-3 byte is sent until port 1 completes with its checksum.
- HDR_EN=0, port 0 sends 0x55, 0xAA → exactly 2 frames, 55 then AA; `tx_start` never overlaps `tx_busy`=1.
- `rst_n` pulsed low during the 2nd frame → `tx_start`, `req_ready` and `pkt_active` go to 0 immediately. A new request after reset begins with SOF and `rr_ptr`=0.
